bus_timeout_watchdog: RTL and testbench
=======================================

// Module: bus_timeout_watchdog
// PURPOSE
//  Monitors every 68k bus cycle alongside the Dtack generator. Consumes AS_L and the final DtackOut_L.
//  If no Dtack arrives within TIMEOUT_CYCLES clocks of AS_L going low, drives BErr_L to the CPU.
//  This stops an unmapped or hung device (DRAM, CanBus, etc.) from hanging the system.
//  Also logs the faulting address and keeps a fault count for the debug monitor.
// PARAMETERS
//  TIMEOUT_CYCLES  256  clocks from AS_L sampled low to BErr_L assertion (legal range 2..65535)
//  ADDR_W          32   width of captured address
//  COUNT_W         8    width of saturating fault counter
// PORTS
//  Clk            in   1        system clock; CPU bus signals are synchronous to it
//  Reset_H        in   1        asynchronous, active-high reset
//  AS_L           in   1        68k address strobe
//  DtackOut_L     in   1        Dtack as driven to the CPU by the Dtack generator
//  Address        in   ADDR_W   68k address bus
//  Enable_H       in   1        1 = watchdog armed; sampled only in IDLE
//  ClearFault_H   in   1        1-cycle pulse: clears FaultValid_H and FaultCount
//  BErr_L         out  1        bus error to CPU, registered
//  Fault_H        out  1        1-cycle pulse on each timeout
//  FaultValid_H   out  1        sticky; set on timeout
//  FaultAddr      out  ADDR_W   Address captured at the most recent timeout
//  FaultCount     out  COUNT_W  number of timeouts, saturating at all-ones
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, BErr_L=1, Fault_H=0, FaultValid_H=0, FaultAddr=0, FaultCount=0.
//  All outputs are registered. Inputs are sampled on the rising edge of Clk.
//  FSM, 4 states:
//   IDLE  : BErr_L=1. If AS_L==0 and Enable_H==1, go to WAIT with cnt=0.
//           If AS_L==0 and Enable_H==0, go to DONE (this cycle is not monitored).
//   WAIT  : priority order at each edge:
//           1. AS_L==1 (aborted cycle): go to IDLE, no fault.
//           2. DtackOut_L==0: go to DONE.
//           3. cnt==TIMEOUT_CYCLES-1: go to FAULT.
//           4. Otherwise cnt++.
//   DONE  : stay until AS_L==1, then go to IDLE. Handles back-to-back cycles without a false fault.
//   FAULT : BErr_L=0. Stay until AS_L==1, then go to IDLE; BErr_L returns to 1 at that edge.
//  Timing: if AS_L is first sampled low at edge k and Dtack never arrives, the FSM enters FAULT at
//   edge k+TIMEOUT_CYCLES. BErr_L is low from just after that edge.
//  Dtack and timeout on the same edge: Dtack wins; no fault.
//  On entry to FAULT, in the same edge: Fault_H=1 for one cycle; FaultAddr<=Address; FaultValid_H<=1;
//   FaultCount<=FaultCount+1, saturating (no wrap to 0).
//  ClearFault_H: FaultValid_H<=0 and FaultCount<=0; FaultAddr is kept.
//   If ClearFault_H coincides with FAULT entry, the fault wins: FaultValid_H=1, FaultCount=1.
//  Enable_H changing mid-cycle has no effect until the FSM is back in IDLE.
//  DtackOut_L is ignored outside WAIT. A Dtack arriving while in FAULT does not release BErr_L.
//  cnt width is clog2(TIMEOUT_CYCLES).
//  Reset mid-cycle: state and BErr_L return to reset values immediately (asynchronous).
// TESTING
//  1. TIMEOUT=4, AS_L low at edge 0, Dtack low at edge 2
//     -> no BErr_L, Fault_H stays 0, FSM IDLE after AS_L high.
//  2. TIMEOUT=4, AS_L low at edge 0, Address=0x00F0_0000, Dtack never
//     -> BErr_L low after edge 4, Fault_H pulses, FaultAddr=0x00F0_0000, FaultCount=1;
//        BErr_L high at the edge AS_L is sampled high.
//  3. TIMEOUT=4, Dtack low exactly at edge 4 -> no fault (Dtack priority).
//  4. AS_L low 2 cycles then high, no Dtack -> no fault; next cycle's counter restarts from 0.
//  5. COUNT_W=2, force 5 timeouts -> FaultCount sticks at 3.
//     ClearFault_H on the same edge as the 6th timeout -> FaultCount=1, FaultValid_H=1.
//  6. Reset_H asserted while in FAULT with BErr_L=0 -> BErr_L=1 and all logs 0 without a clock edge;
//     Enable_H=0 cycle with no Dtack -> never faults.

Source files
------------

// File: rtl/bus_timeout_watchdog_if.sv
// Bus-side signals shared between the 68k bus / Dtack generator and the timeout watchdog.
// slave is the watchdog's view; master is the CPU/bus side that drives the strobes.
interface bus_timeout_watchdog_if #(
  parameter int ADDR_W  = 32,
  parameter int COUNT_W = 8
);
  logic              AS_L;
  logic              DtackOut_L;
  logic [ADDR_W-1:0] Address;
  logic              Enable_H;
  logic              ClearFault_H;
  logic              BErr_L;
  logic              Fault_H;
  logic              FaultValid_H;
  logic [ADDR_W-1:0] FaultAddr;
  logic [COUNT_W-1:0] FaultCount;

  modport slave (
    input  AS_L, DtackOut_L, Address, Enable_H, ClearFault_H,
    output BErr_L, Fault_H, FaultValid_H, FaultAddr, FaultCount
  );

  modport master (
    output AS_L, DtackOut_L, Address, Enable_H, ClearFault_H,
    input  BErr_L, Fault_H, FaultValid_H, FaultAddr, FaultCount
  );
endinterface

// File: rtl/bus_timeout_watchdog.sv
// Watches each 68k bus cycle and raises BErr_L if no Dtack arrives within TIMEOUT_CYCLES clocks.
// Also records the faulting address and a saturating fault count for the debug monitor.
module bus_timeout_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 32,
  parameter int COUNT_W        = 8
) (
  input logic                    Clk,
  input logic                    Reset_H,
  bus_timeout_watchdog_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, FAULT} stateT;

  stateT              state;
  stateT              stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cntNext;
  logic               faultEntry;

  logic               berrQ;
  logic               faultPulseQ;
  logic               faultValidQ;
  logic [ADDR_W-1:0]  faultAddrQ;
  logic [COUNT_W-1:0] faultCountQ;

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Abort beats Dtack, and Dtack beats the timeout when both land on the same edge.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    faultEntry = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.AS_L) begin
          if (bus.Enable_H) begin
            stateNext = WAIT;
            cntNext   = '0;
          end else begin
            stateNext = DONE;
          end
        end
      end
      WAIT: begin
        if (bus.AS_L) begin
          stateNext = IDLE;
        end else if (!bus.DtackOut_L) begin
          stateNext = DONE;
        end else if (cnt == CNT_MAX) begin
          stateNext  = FAULT;
          faultEntry = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DONE: begin
        if (bus.AS_L) stateNext = IDLE;
      end
      FAULT: begin
        if (bus.AS_L) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A fault on the same edge as a clear wins, leaving exactly one logged fault.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      berrQ       <= 1'b1;
      faultPulseQ <= 1'b0;
      faultValidQ <= 1'b0;
      faultAddrQ  <= '0;
      faultCountQ <= '0;
    end else begin
      berrQ       <= (stateNext != FAULT);
      faultPulseQ <= faultEntry;
      if (faultEntry) begin
        faultValidQ <= 1'b1;
        faultAddrQ  <= bus.Address;
        if (bus.ClearFault_H) begin
          faultCountQ <= COUNT_W'(1);
        end else if (faultCountQ != {COUNT_W{1'b1}}) begin
          faultCountQ <= faultCountQ + 1'b1;
        end
      end else if (bus.ClearFault_H) begin
        faultValidQ <= 1'b0;
        faultCountQ <= '0;
      end
    end
  end

  assign bus.BErr_L       = berrQ;
  assign bus.Fault_H      = faultPulseQ;
  assign bus.FaultValid_H = faultValidQ;
  assign bus.FaultAddr    = faultAddrQ;
  assign bus.FaultCount   = faultCountQ;

endmodule

// File: tb/tb_bus_timeout_watchdog.sv
// Self-checking bench for bus_timeout_watchdog: directed cases plus randomized bus cycles
// checked against an edge-indexed model of when a cycle must time out.
module tb_bus_timeout_watchdog;

  localparam int T       = 4;
  localparam int ADDR_W  = 32;
  localparam int COUNT_W = 2;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic Clk;
  logic Reset_H;

  int total;
  int bad;

  bit                mValid;
  int                mCount;
  logic [ADDR_W-1:0] mAddr;

  bus_timeout_watchdog_if #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) bus ();

  bus_timeout_watchdog #(
    .TIMEOUT_CYCLES(T),
    .ADDR_W(ADDR_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .Clk(Clk),
    .Reset_H(Reset_H),
    .bus(bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One bus cycle: AS_L low for edges 0..len-1, high at edge len. Dtack held low from edge
  // dly (0 = never) while AS_L is low. A cycle times out at edge T iff it was enabled at edge 0,
  // AS_L is still low at edge T, and Dtack did not show up at or before edge T.
  task automatic doBusCycle(input bit en, input int len, input int dly, input int clr,
                            input int gap, input logic [ADDR_W-1:0] fixAddr);
    bit faults;
    bit expBerr;
    bit expPulse;
    faults = en && (len > T) && (dly == 0 || dly > T);
    for (int j = 0; j <= len; j++) begin
      bus.AS_L         = (j < len) ? 1'b0 : 1'b1;
      bus.DtackOut_L   = (dly != 0 && j >= dly && j < len) ? 1'b0 : 1'b1;
      bus.Enable_H     = (j == 0) ? en : 1'($urandom_range(0, 1));
      bus.Address      = (fixAddr != '0) ? fixAddr : ADDR_W'($urandom);
      bus.ClearFault_H = (j == clr);
      tick();
      expPulse = faults && (j == T);
      if (expPulse) begin
        mValid = 1'b1;
        mAddr  = bus.Address;
        if (j == clr) mCount = 1;
        else if (mCount < CMAX) mCount = mCount + 1;
      end else if (j == clr) begin
        mValid = 1'b0;
        mCount = 0;
      end
      expBerr = !(faults && j >= T && j < len);
      total += 5;
      if (bus.BErr_L !== expBerr) begin
        bad++;
        $display("[TB] FAIL berr edge=%0d got=%b want=%b", j, bus.BErr_L, expBerr);
      end
      if (bus.Fault_H !== expPulse) begin
        bad++;
        $display("[TB] FAIL faultPulse edge=%0d got=%b want=%b", j, bus.Fault_H, expPulse);
      end
      if (bus.FaultValid_H !== mValid) begin
        bad++;
        $display("[TB] FAIL faultValid edge=%0d got=%b want=%b", j, bus.FaultValid_H, mValid);
      end
      if (bus.FaultCount !== COUNT_W'(mCount)) begin
        bad++;
        $display("[TB] FAIL faultCount edge=%0d got=%0d want=%0d", j, bus.FaultCount, mCount);
      end
      if (bus.FaultAddr !== mAddr) begin
        bad++;
        $display("[TB] FAIL faultAddr edge=%0d got=%h want=%h", j, bus.FaultAddr, mAddr);
      end
    end
    bus.ClearFault_H = 1'b0;
    bus.DtackOut_L   = 1'b1;
    for (int g = 0; g < gap; g++) begin
      bus.Enable_H = 1'($urandom_range(0, 1));
      tick();
      total += 2;
      if (bus.BErr_L !== 1'b1) begin
        bad++;
        $display("[TB] FAIL berrIdle got=%b want=1", bus.BErr_L);
      end
      if (bus.Fault_H !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pulseIdle got=%b want=0", bus.Fault_H);
      end
    end
  endtask

  task automatic test_reset();
    Reset_H          = 1'b1;
    bus.AS_L         = 1'b1;
    bus.DtackOut_L   = 1'b1;
    bus.Address      = '0;
    bus.Enable_H     = 1'b1;
    bus.ClearFault_H = 1'b0;
    mValid = 1'b0;
    mCount = 0;
    mAddr  = '0;
    #12;
    total += 5;
    if (bus.BErr_L !== 1'b1) begin bad++; $display("[TB] FAIL resetBerr got=%b want=1", bus.BErr_L); end
    if (bus.Fault_H !== 1'b0) begin bad++; $display("[TB] FAIL resetPulse got=%b want=0", bus.Fault_H); end
    if (bus.FaultValid_H !== 1'b0) begin bad++; $display("[TB] FAIL resetValid got=%b want=0", bus.FaultValid_H); end
    if (bus.FaultCount !== '0) begin bad++; $display("[TB] FAIL resetCount got=%0d want=0", bus.FaultCount); end
    if (bus.FaultAddr !== '0) begin bad++; $display("[TB] FAIL resetAddr got=%h want=0", bus.FaultAddr); end
    Reset_H = 1'b0;
    tick();
  endtask

  task automatic test_dtack_ok();
    doBusCycle(1'b1, 4, 2, -1, 1, '0);
  endtask

  task automatic test_timeout();
    doBusCycle(1'b1, T + 3, 0, -1, 1, 32'h00F0_0000);
    total += 2;
    if (bus.FaultAddr !== 32'h00F0_0000) begin
      bad++;
      $display("[TB] FAIL timeoutAddr got=%h want=00f00000", bus.FaultAddr);
    end
    if (bus.FaultCount !== COUNT_W'(1)) begin
      bad++;
      $display("[TB] FAIL timeoutCount got=%0d want=1", bus.FaultCount);
    end
  endtask

  task automatic test_dtack_priority();
    doBusCycle(1'b1, T + 2, T, -1, 1, '0);
    doBusCycle(1'b1, T + 3, T + 1, -1, 1, '0);
  endtask

  task automatic test_abort_restart();
    doBusCycle(1'b1, 2, 0, -1, 0, '0);
    doBusCycle(1'b1, T + 2, 0, -1, 1, '0);
  endtask

  task automatic test_saturate_clear();
    bus.ClearFault_H = 1'b1;
    tick();
    bus.ClearFault_H = 1'b0;
    mValid = 1'b0;
    mCount = 0;
    total += 3;
    if (bus.FaultValid_H !== 1'b0) begin bad++; $display("[TB] FAIL clearValid got=%b want=0", bus.FaultValid_H); end
    if (bus.FaultCount !== '0) begin bad++; $display("[TB] FAIL clearCount got=%0d want=0", bus.FaultCount); end
    if (bus.FaultAddr !== mAddr) begin bad++; $display("[TB] FAIL clearKeepsAddr got=%h want=%h", bus.FaultAddr, mAddr); end
    for (int k = 0; k < 5; k++) doBusCycle(1'b1, T + 1, 0, -1, 0, '0);
    total += 1;
    if (bus.FaultCount !== COUNT_W'(CMAX)) begin
      bad++;
      $display("[TB] FAIL saturate got=%0d want=%0d", bus.FaultCount, CMAX);
    end
    doBusCycle(1'b1, T + 2, 0, T, 1, '0);
    total += 2;
    if (bus.FaultCount !== COUNT_W'(1)) begin bad++; $display("[TB] FAIL clearVsFaultCount got=%0d want=1", bus.FaultCount); end
    if (bus.FaultValid_H !== 1'b1) begin bad++; $display("[TB] FAIL clearVsFaultValid got=%b want=1", bus.FaultValid_H); end
  endtask

  task automatic test_disabled();
    doBusCycle(1'b0, T + 6, 0, -1, 1, '0);
  endtask

  task automatic test_reset_in_fault();
    bus.AS_L       = 1'b0;
    bus.Enable_H   = 1'b1;
    bus.DtackOut_L = 1'b1;
    bus.Address    = 32'h1234_5678;
    for (int j = 0; j <= T; j++) tick();
    total += 2;
    if (bus.BErr_L !== 1'b0) begin bad++; $display("[TB] FAIL preResetBerr got=%b want=0", bus.BErr_L); end
    if (bus.FaultAddr !== 32'h1234_5678) begin bad++; $display("[TB] FAIL preResetAddr got=%h want=12345678", bus.FaultAddr); end
    #2;
    Reset_H = 1'b1;
    #1;
    mValid = 1'b0;
    mCount = 0;
    mAddr  = '0;
    total += 5;
    if (bus.BErr_L !== 1'b1) begin bad++; $display("[TB] FAIL asyncBerr got=%b want=1", bus.BErr_L); end
    if (bus.Fault_H !== 1'b0) begin bad++; $display("[TB] FAIL asyncPulse got=%b want=0", bus.Fault_H); end
    if (bus.FaultValid_H !== 1'b0) begin bad++; $display("[TB] FAIL asyncValid got=%b want=0", bus.FaultValid_H); end
    if (bus.FaultCount !== '0) begin bad++; $display("[TB] FAIL asyncCount got=%0d want=0", bus.FaultCount); end
    if (bus.FaultAddr !== '0) begin bad++; $display("[TB] FAIL asyncAddr got=%h want=0", bus.FaultAddr); end
    bus.AS_L = 1'b1;
    @(negedge Clk);
    Reset_H = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) doBusCycle(1'b1, 3, 1 + (k % 2), -1, 0, '0);
    doBusCycle(1'b1, T + 2, 0, -1, 0, '0);
    doBusCycle(1'b1, 3, 2, -1, 1, '0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      bit en;
      int len;
      int dly;
      int clr;
      int gap;
      en  = ($urandom_range(0, 4) != 0);
      len = $urandom_range(1, T + 4);
      dly = $urandom_range(0, T + 3);
      clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      gap = $urandom_range(0, 2);
      doBusCycle(en, len, dly, clr, gap, '0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_dtack_ok();
    test_timeout();
    test_dtack_priority();
    test_abort_restart();
    test_saturate_clear();
    test_disabled();
    test_back_to_back();
    test_reset_in_fault();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
